// File: rtl/rr_array_arbiter.sv
// rtl/rr_array_arbiter.sv - round-robin arbiter granting a shared systolic array to one requester at a time
// Two-state FSM: IDLE arbitrates from the one-hot pointer, BUSY holds the grant until done_i.
module rr_array_arbiter #(
  parameter int req_p  = 4,
  parameter int id_w_p = $clog2(req_p)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [req_p-1:0]  req_i,
  input  logic              done_i,
  output logic [req_p-1:0]  grant_o,
  output logic [id_w_p-1:0] grant_id_o,
  output logic              busy_o,
  output logic [req_p-1:0]  ptr_o
);

  typedef enum logic {IDLE_S, BUSY_S} state_e;

  state_e              state_q, state_d;
  logic [req_p-1:0]    grant_q, grant_d;
  logic [req_p-1:0]    ptr_q, ptr_d;
  logic [id_w_p-1:0]   grant_id_q, grant_id_d;
  logic [req_p-1:0]    win_oh;
  logic [id_w_p-1:0]   win_id;
  logic                found;
  int                  idx;

  // Scan from the hot pointer bit upward with wrap; the pointer is one-hot so one outer pass fires.
  always_comb begin
    win_oh = '0;
    win_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int s = 0; s < req_p; s++) begin
      if (ptr_q[s]) begin
        for (int k = 0; k < req_p; k++) begin
          idx = (s + k) % req_p;
          if (!found && req_i[idx]) begin
            found       = 1'b1;
            win_oh      = '0;
            win_oh[idx] = 1'b1;
            win_id      = idx[id_w_p-1:0];
          end
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    case (state_q)
      IDLE_S: begin
        if (found) begin
          state_d    = BUSY_S;
          grant_d    = win_oh;
          grant_id_d = win_id;
        end
      end
      BUSY_S: begin
        if (done_i) begin
          state_d    = IDLE_S;
          grant_d    = '0;
          grant_id_d = '0;
          ptr_d      = {grant_q[req_p-2:0], grant_q[req_p-1]};
        end
      end
      default: state_d = IDLE_S;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE_S;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= {{(req_p-1){1'b0}}, 1'b1};
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
    end
  end

  assign grant_o    = grant_q;
  assign grant_id_o = grant_id_q;
  assign busy_o     = (state_q == BUSY_S);
  assign ptr_o      = ptr_q;

endmodule

// File: tb/tb_rr_array_arbiter.sv
// tb/tb_rr_array_arbiter.sv - directed vector bench for rr_array_arbiter
// Vector table covers reset, hold, release, wrap; a hand sequence covers round-robin fairness.
module tb_rr_array_arbiter;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [3:0] req_i;
  logic       done_i;
  logic [3:0] grant_o;
  logic [1:0] grant_id_o;
  logic       busy_o;
  logic [3:0] ptr_o;

  int tests_run = 0;
  int tests_failed = 0;

  rr_array_arbiter #(.req_p(4)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .req_i      (req_i),
    .done_i     (done_i),
    .grant_o    (grant_o),
    .grant_id_o (grant_id_o),
    .busy_o     (busy_o),
    .ptr_o      (ptr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    logic [3:0] p;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic step(input logic rst, input logic [3:0] req, input logic done);
    @(negedge clk_i);
    reset_i = rst;
    req_i   = req;
    done_i  = done;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] g, input logic [1:0] id,
                       input logic b, input logic [3:0] p);
    tests_run++;
    if (grant_o !== g || grant_id_o !== id || busy_o !== b || ptr_o !== p) begin
      tests_failed++;
      $display("FAIL %s: got grant=%b id=%0d busy=%b ptr=%b, expected grant=%b id=%0d busy=%b ptr=%b",
               name, grant_o, grant_id_o, busy_o, ptr_o, g, id, b, p);
    end
  endtask

  initial begin
    logic [3:0] fair_ptr;
    reset_i = 1'b1;
    req_i   = '0;
    done_i  = 1'b0;

    //             rst  req      done grant    id  busy ptr
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0001};
    vecs[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0001};
    vecs[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0001};
    vecs[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0001};
    vecs[4]  = '{1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0001};
    vecs[5]  = '{1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0001};
    vecs[6]  = '{1'b0, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0001};
    vecs[7]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0001};
    vecs[8]  = '{1'b0, 4'b0110, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0100};
    vecs[9]  = '{1'b0, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0100};
    vecs[10] = '{1'b0, 4'b0110, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b1000};
    vecs[11] = '{1'b0, 4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b1000};
    vecs[12] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0100};
    vecs[13] = '{1'b0, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 4'b0100};
    vecs[14] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0001};
    vecs[15] = '{1'b0, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0001};
    vecs[16] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0010};
    vecs[17] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0010};
    vecs[18] = '{1'b1, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0001};
    vecs[19] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0001};
    vecs[20] = '{1'b1, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0001};
    vecs[21] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0001};

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done);
      check($sformatf("vec%0d", i), vecs[i].g, vecs[i].id, vecs[i].b, vecs[i].p);
    end

    // All requesters held: grants rotate 0,1,2,3,0 with one idle cycle between each.
    fair_ptr = 4'b0001;
    for (int n = 0; n < 5; n++) begin
      logic [1:0] exp_id;
      logic [3:0] exp_g;
      exp_id = 2'(n % 4);
      exp_g  = 4'b0001 << exp_id;
      step(1'b0, 4'b1111, 1'b0);
      check($sformatf("fair_grant%0d", n), exp_g, exp_id, 1'b1, fair_ptr);
      step(1'b0, 4'b1111, 1'b0);
      check($sformatf("fair_hold%0d", n), exp_g, exp_id, 1'b1, fair_ptr);
      fair_ptr = {exp_g[2:0], exp_g[3]};
      step(1'b0, 4'b1111, 1'b1);
      check($sformatf("fair_gap%0d", n), 4'b0000, 2'd0, 1'b0, fair_ptr);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rr_array_arbiter.md
RR_ARRAY_ARBITER -- requirements
Module: rr_array_arbiter

Interface
REQ-001 Parameter: req_p, default 4, number of requesters sharing the systolic array; legal range 2..16.
REQ-002 Parameter: id_w_p, default $clog2(req_p), width of grant_id_o.
REQ-003 clk_i  input  1  single clock; all state updates on posedge clk_i.
REQ-004 reset_i  input  1  reset, synchronous, active-high.
REQ-005 req_i  input  req_p  per-requester request for the array; level-sensitive.
REQ-006 done_i  input  1  asserted by the array for one cycle when the granted job completes.
REQ-007 grant_o  output  req_p  registered grant; one-hot or all-zero.
REQ-008 grant_id_o  output  id_w_p  binary index of the hot bit of grant_o; 0 when grant_o is zero.
REQ-009 busy_o  output  1  high while a grant is held.
REQ-010 ptr_o  output  req_p  one-hot round-robin priority pointer, for debug and coverage.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (no grant) and BUSY (grant held).
REQ-012 The priority pointer SHALL be one-hot at all times after reset; a zero or multi-hot pointer is unreachable.
REQ-013 In IDLE with req_i nonzero, the winner SHALL be the first set req_i bit found starting at the pointer bit inclusive, ascending, wrapping from bit req_p-1 to bit 0.
REQ-014 The winner's grant SHALL appear on grant_o the cycle after req_i is sampled (1-cycle latency), with the FSM entering BUSY and busy_o rising in that same cycle.
REQ-015 In IDLE with req_i zero, the block SHALL stay in IDLE with grant_o zero and the pointer unchanged.
REQ-016 In BUSY, grant_o, grant_id_o and the pointer SHALL hold, independent of req_i; deassertion of the granted request does not release the grant.
REQ-017 In BUSY, done_i SHALL cause, on the next edge: grant_o cleared, busy_o low, state IDLE.
REQ-018 On that same edge, the pointer SHALL become the released grant rotated left by one, with bit req_p-1 wrapping to bit 0.
REQ-019 The block SHALL insert exactly one IDLE cycle between consecutive grants; a request present in the done_i cycle is arbitrated in the following IDLE cycle.
REQ-020 done_i asserted in IDLE SHALL be ignored: no state or pointer change.
REQ-021 Multi-cycle done_i in BUSY SHALL release once; the remainder falls in IDLE per REQ-020.
REQ-022 grant_id_o SHALL be registered alongside grant_o and always consistent with it.
REQ-023 Fairness: with all requesters continuously asserted, grants SHALL cycle 0,1,...,req_p-1,0,...; no requester waits more than req_p grants.

Reset
REQ-024 On reset_i high at a clock edge, the block SHALL set state IDLE, grant_o 0, grant_id_o 0, busy_o 0 and ptr_o 1 (bit 0 hot).
REQ-025 Reset SHALL override done_i and req_i in the same cycle.
REQ-026 Reset asserted during BUSY SHALL drop the grant on the next edge with no pointer rotation.
REQ-027 The first arbitration after reset SHALL occur on the first edge with reset_i low and req_i nonzero.

Verification
REQ-028 Reset then req_i=4'b0110 held -> grant_o=4'b0010 one cycle later, grant_id_o=1, busy_o=1, ptr_o=4'b0001.
REQ-029 From REQ-028, pulse done_i -> next cycle grant_o=0, ptr_o=4'b0100; following cycle grant_o=4'b0100, grant_id_o=2.
REQ-030 req_i=4'b1111 held, done_i pulsed once per grant -> grant_id_o sequence 0,1,2,3,0, each grant separated by one zero-grant cycle.
REQ-031 Pointer wrap: grant 4'b1000 released -> ptr_o=4'b0001; then req_i=4'b1001 -> grant_o=4'b0001.
REQ-032 Grant 4'b0010, requester 1 drops req, done_i low 5 cycles -> grant_o held at 4'b0010; done_i in IDLE -> no change.
REQ-033 Reset asserted while grant_o=4'b0100 -> next cycle grant_o=0, busy_o=0, ptr_o=4'b0001.
